bist_main: RTL and testbench
============================

// Module: bist_main
// PURPOSE
//  Self-test top: on-chip BIST around a K/J symbol sync detector (CUT). An LFSR drives the CUT
//  inputs, a MISR compacts the CUT outputs, and a controller compares the final signature to a
//  golden value. Sits at chip top; the only external inputs are clk, rst and bist_start.
// PARAMETERS
//  N_PATTERNS  255        LFSR patterns applied per run
//  SYNC_LEN    3          consecutive valid K symbols needed to acquire sync
//  GOLDEN_SIG  16'h0000   fault-free MISR signature; bench overrides with model-computed value
// PORTS
//  clk             in   1   single clock, all logic on posedge
//  rst             in   1   asynchronous, active-low reset
//  bist_start      in   1   level; high while idle starts a BIST run
//  bist_end        out  1   high when the run is complete (held)
//  pass_fail       out  1   1 = signature matched GOLDEN_SIG; valid only while bist_end=1
//  in_k            out  1   CUT stimulus K line (observable)
//  in_j            out  1   CUT stimulus J line (observable)
//  in_en           out  1   CUT stimulus symbol-valid (observable)
//  out_synced_d    out  1   registered CUT sync flag
//  out_sync_err_d  out  1   registered CUT sync-error pulse
// BEHAVIOUR
//  Reset (rst=0): FSM=IDLE, LFSR=8'h01, MISR=0, count=0; every output 0.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; shifts only in RUN. in_k=lfsr[0], in_j=lfsr[1],
//   in_en=lfsr[2]|lfsr[3]. Outside RUN all three stimulus outputs are 0.
//  CUT (sync detector), valid symbol = in_en=1 cycle:
//   K = k&~j, J = ~k&j, illegal = k&j, idle = ~k&~j.
//   Not synced: valid K increments kcnt; any other valid symbol clears kcnt; kcnt reaching
//    SYNC_LEN sets synced, clears kcnt.
//   Synced: valid illegal symbol -> synced=0 and one-cycle sync_err; else synced holds.
//   in_en=0 cycles change nothing. out_synced_d/out_sync_err_d = those flags, 1 cycle later.
//  MISR: 16-bit, poly x^16+x^12+x^5+1; each RUN/FLUSH cycle: shift, then bit0^=out_synced_d,
//   bit1^=out_sync_err_d.
//  FSM:
//   IDLE  : bist_start=1 -> RUN; re-seed LFSR=8'h01, MISR=0, CUT state cleared, count=0.
//   RUN   : N_PATTERNS cycles of stimulus; count==N_PATTERNS-1 -> FLUSH.
//   FLUSH : 2 cycles, stimulus 0, MISR still captures pipeline outputs -> DONE.
//   DONE  : bist_end=1, pass_fail=(MISR==GOLDEN_SIG), both held; stays until bist_start=0
//           -> IDLE (bist_end, pass_fail return 0).
//  bist_start ignored outside IDLE/DONE; deasserting mid-run does not abort.
//  Async reset mid-run aborts immediately to reset state.
//  Latency bist_start -> bist_end = N_PATTERNS+3 cycles (258 with defaults).
// STRUCTURE
//  Package bist_pkg: FSM state enum (IDLE,RUN,FLUSH,DONE), LFSR seed/taps, MISR poly.
//  Sub-module sync_detector (CUT: kcnt, synced, sync_err, output regs); rest (LFSR, MISR,
//  counter, FSM) inline in bist_main.
// TESTING
//  1 Reset: rst=0 -> all outputs 0; release rst, bist_start=0 for 10 cycles -> outputs stay 0.
//  2 Full run: bist_start=1 -> bist_end rises exactly 258 cycles later, pass_fail=1 with
//    GOLDEN_SIG from a bench reference model of LFSR+CUT+MISR.
//  3 Stimulus check: first RUN cycles in_k/in_j/in_en match model LFSR from seed 8'h01.
//  4 CUT direct: 3 valid K -> out_synced_d=1 one cycle after third; valid k=j=1 ->
//    out_sync_err_d pulses 1 cycle, out_synced_d=0.
//  5 Fault: force a wrong GOLDEN_SIG (e.g. 16'hFFFF) -> bist_end=1, pass_fail=0.
//  6 Reset mid-run (cycle 100) -> all 0; restart -> identical signature/pass as scenario 2.

Source files
------------

// File: rtl/bist_pkg.sv
// ============================================================================
// Module : bist_pkg
// Brief  : Shared BIST types and constants: FSM states, LFSR seed/taps, MISR poly.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam logic [7:0]  LFSR_SEED = 8'h01;
    // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
    localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [1:0] d);
        logic [15:0] n;
        n      = {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000);
        n[1:0] = n[1:0] ^ d;
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_detector.sv
// ============================================================================
// Module : sync_detector
// Brief  : K/J symbol sync detector (BIST circuit under test) with output regs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_detector #(
    parameter int SYNC_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic k,
    input  logic j,
    input  logic en,
    output logic synced_d,
    output logic sync_err_d
);

    localparam int KW = $clog2(SYNC_LEN + 1);

    logic [KW-1:0] kcnt;
    logic          synced;
    logic          sync_err;
    logic          sym_k;
    logic          sym_bad;

    assign sym_k   = en & k & ~j;
    assign sym_bad = en & k & j;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kcnt       <= '0;
            synced     <= 1'b0;
            sync_err   <= 1'b0;
            synced_d   <= 1'b0;
            sync_err_d <= 1'b0;
        end else if (clear) begin
            kcnt       <= '0;
            synced     <= 1'b0;
            sync_err   <= 1'b0;
            synced_d   <= 1'b0;
            sync_err_d <= 1'b0;
        end else begin
            synced_d   <= synced;
            sync_err_d <= sync_err;
            sync_err   <= synced & sym_bad;
            if (en) begin
                if (!synced) begin
                    if (sym_k) begin
                        if (kcnt == KW'(SYNC_LEN - 1)) begin
                            synced <= 1'b1;
                            kcnt   <= '0;
                        end else begin
                            kcnt <= kcnt + 1'b1;
                        end
                    end else begin
                        kcnt <= '0;
                    end
                end else if (sym_bad) begin
                    synced <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bist_main.sv
// ============================================================================
// Module : bist_main
// Brief  : BIST top: LFSR stimulus -> sync_detector -> MISR, golden compare.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bist_main
    import bist_pkg::*;
#(
    parameter int          N_PATTERNS = 255,
    parameter int          SYNC_LEN   = 3,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic clk,
    input  logic rst,
    input  logic bist_start,
    output logic bist_end,
    output logic pass_fail,
    output logic in_k,
    output logic in_j,
    output logic in_en,
    output logic out_synced_d,
    output logic out_sync_err_d
);

    localparam int            CW   = (N_PATTERNS > 2) ? $clog2(N_PATTERNS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_PATTERNS - 1);

    bist_state_t   state;
    bist_state_t   state_nxt;
    logic          start_run;
    logic          running;
    logic [7:0]    lfsr;
    logic [15:0]   misr;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        case (state)
            IDLE: begin
                if (bist_start) begin
                    state_nxt = RUN;
                    start_run = 1'b1;
                end
            end
            RUN:     if (count == LAST)    state_nxt = FLUSH;
            FLUSH:   if (count == CW'(1))  state_nxt = DONE;
            DONE:    if (!bist_start)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // count tracks patterns in RUN, then is reused for the two flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr  <= LFSR_SEED;
            misr  <= '0;
            count <= '0;
        end else if (start_run) begin
            lfsr  <= LFSR_SEED;
            misr  <= '0;
            count <= '0;
        end else begin
            if (state == RUN)
                lfsr <= lfsr_next(lfsr);
            if (state == RUN || state == FLUSH)
                misr <= misr_next(misr, {out_sync_err_d, out_synced_d});
            if (state == RUN)
                count <= (count == LAST) ? '0 : count + 1'b1;
            else if (state == FLUSH)
                count <= count + 1'b1;
        end
    end

    assign running   = (state == RUN);
    assign in_k      = running & lfsr[0];
    assign in_j      = running & lfsr[1];
    assign in_en     = running & (lfsr[2] | lfsr[3]);
    assign bist_end  = (state == DONE);
    assign pass_fail = (state == DONE) && (misr == GOLDEN_SIG);

    sync_detector #(
        .SYNC_LEN (SYNC_LEN)
    ) u_cut (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_run),
        .k          (in_k),
        .j          (in_j),
        .en         (in_en),
        .synced_d   (out_synced_d),
        .sync_err_d (out_sync_err_d)
    );

endmodule

`default_nettype wire

// File: tb/tb_bist_main.sv
// ============================================================================
// Module : tb_bist_main
// Brief  : Self-checking bench for bist_main and its sync_detector CUT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bist_main;

    localparam int N    = 255;
    localparam int SLEN = 3;

    // Per-symbol CUT flags (synced / error pulse after each pattern) from the spec rules.
    function automatic logic [N-1:0] model_flags(input logic want_err);
        logic [7:0]   l;
        logic [N-1:0] sa;
        logic [N-1:0] ea;
        int           kc;
        logic         sy;
        logic         k, j, en;
        l  = 8'h01;
        kc = 0;
        sy = 1'b0;
        sa = '0;
        ea = '0;
        for (int i = 0; i < N; i++) begin
            k  = l[0];
            j  = l[1];
            en = l[2] | l[3];
            if (en) begin
                if (!sy) begin
                    if (k && !j) begin
                        kc = kc + 1;
                        if (kc == SLEN) begin
                            sy = 1'b1;
                            kc = 0;
                        end
                    end else begin
                        kc = 0;
                    end
                end else if (k && j) begin
                    sy    = 1'b0;
                    ea[i] = 1'b1;
                end
            end
            sa[i] = sy;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return want_err ? ea : sa;
    endfunction

    function automatic logic [15:0] model_sig();
        logic [N-1:0] sa;
        logic [N-1:0] ea;
        logic [15:0]  m;
        logic         sd, ed;
        sa = model_flags(1'b0);
        ea = model_flags(1'b1);
        m  = 16'h0000;
        // N pattern cycles plus 2 flush cycles; each sees the flags from 3 edges earlier.
        for (int t = 1; t <= N + 2; t++) begin
            sd = (t >= 3) ? sa[t-3] : 1'b0;
            ed = (t >= 3) ? ea[t-3] : 1'b0;
            m  = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000);
            m[0] = m[0] ^ sd;
            m[1] = m[1] ^ ed;
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = model_sig();

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bist_start = 1'b0;
    logic bist_end, pass_fail, in_k, in_j, in_en, out_synced_d, out_sync_err_d;
    logic bad_end, bad_pf, bad_k, bad_j, bad_en, bad_sd, bad_ed;
    logic c_clear = 1'b0, c_k = 1'b0, c_j = 1'b0, c_en = 1'b0;
    logic c_sd, c_ed;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bist_main #(.N_PATTERNS(N), .SYNC_LEN(SLEN), .GOLDEN_SIG(GOLD)) dut (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_end(bist_end),
        .pass_fail(pass_fail), .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .out_synced_d(out_synced_d), .out_sync_err_d(out_sync_err_d)
    );

    bist_main #(.N_PATTERNS(N), .SYNC_LEN(SLEN), .GOLDEN_SIG(16'hFFFF)) dut_bad (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_end(bad_end),
        .pass_fail(bad_pf), .in_k(bad_k), .in_j(bad_j), .in_en(bad_en),
        .out_synced_d(bad_sd), .out_sync_err_d(bad_ed)
    );

    sync_detector #(.SYNC_LEN(SLEN)) cut (
        .clk(clk), .rst(rst), .clear(c_clear), .k(c_k), .j(c_j), .en(c_en),
        .synced_d(c_sd), .sync_err_d(c_ed)
    );

    typedef struct packed {
        logic k;
        logic j;
        logic en;
        logic sd;
        logic ed;
    } vec_t;

    vec_t tbl [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [13:0] all_outs();
        return {bist_end, pass_fail, in_k, in_j, in_en, out_synced_d, out_sync_err_d,
                bad_end, bad_pf, bad_k, bad_j, bad_en, bad_sd, bad_ed};
    endfunction

    // Runs one BIST pass; abort_at>0 asserts reset at that cycle. lat = cycles to bist_end.
    task automatic run_bist(input int abort_at, output int lat);
        logic [7:0]   ml;
        logic [N-1:0] sa;
        logic [N-1:0] ea;
        logic         exp_sd, exp_ed;
        sa  = model_flags(1'b0);
        ea  = model_flags(1'b1);
        ml  = 8'h01;
        lat = 0;
        bist_start = 1'b1;
        for (int e = 1; e <= 400; e++) begin
            tick();
            if (e == abort_at) begin
                bist_start = 1'b0;
                rst = 1'b0;
                #1;
                check("abort_outputs_zero", 32'(all_outs()), 32'h0);
                lat = -1;
                return;
            end
            if (e <= N) begin
                check("stim_k",  32'(in_k),  32'(ml[0]));
                check("stim_j",  32'(in_j),  32'(ml[1]));
                check("stim_en", 32'(in_en), 32'(ml[2] | ml[3]));
                ml = {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
            end else if (e <= N + 3) begin
                check("stim_idle", 32'({in_k, in_j, in_en}), 32'h0);
            end
            if (e <= N + 3) begin
                exp_sd = (e < 3) ? 1'b0 : sa[(e - 3 < N) ? e - 3 : N - 1];
                exp_ed = (e >= 3 && e - 3 < N) ? ea[e-3] : 1'b0;
                check("run_synced_d",   32'(out_synced_d),   32'(exp_sd));
                check("run_sync_err_d", 32'(out_sync_err_d), 32'(exp_ed));
            end
            if (bist_end) begin
                lat = e;
                break;
            end
            bist_start = (e < N) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic check_done(input int lat);
        check("latency", 32'(lat), 32'(N + 3));
        check("pass_fail_gold", 32'(pass_fail), 32'h1);
        check("bad_end", 32'(bad_end), 32'h1);
        check("bad_pass_fail", 32'(bad_pf), 32'(GOLD == 16'hFFFF));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_hold", 32'({bist_end, pass_fail}), 32'h3);
        end
        bist_start = 1'b0;
        tick();
        check("done_release", 32'({bist_end, pass_fail, bad_end, bad_pf}), 32'h0);
    endtask

    initial begin
        int   lat;
        int   kc;
        logic sy, er, prev_sy, prev_er;
        logic k, j, en;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset_outputs", 32'(all_outs()), 32'h0);
        check("reset_cut", 32'({c_sd, c_ed}), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outputs", 32'(all_outs()), 32'h0);
        end

        // CUT directed vectors
        c_clear = 1'b1;
        tick();
        c_clear = 1'b0;
        for (int i = 0; i < 19; i++) begin
            c_k  = tbl[i].k;
            c_j  = tbl[i].j;
            c_en = tbl[i].en;
            tick();
            check($sformatf("cut_vec%0d_synced_d", i), 32'(c_sd), 32'(tbl[i].sd));
            check($sformatf("cut_vec%0d_err_d", i), 32'(c_ed), 32'(tbl[i].ed));
        end

        // CUT random symbols against a rule-level model
        kc = 0;
        sy = 1'b0;
        er = 1'b0;
        for (int i = 0; i < 300; i++) begin
            k  = 1'($urandom_range(0, 1));
            j  = ($urandom_range(0, 3) == 0) ? k : 1'b0;
            en = ($urandom_range(0, 3) != 0);
            prev_sy = sy;
            prev_er = er;
            er = 1'b0;
            if (en) begin
                if (!sy) begin
                    if (k && !j) begin
                        kc++;
                        if (kc == SLEN) begin
                            sy = 1'b1;
                            kc = 0;
                        end
                    end else begin
                        kc = 0;
                    end
                end else if (k && j) begin
                    sy = 1'b0;
                    er = 1'b1;
                end
            end
            c_k  = k;
            c_j  = j;
            c_en = en;
            tick();
            check("cut_rand_synced_d", 32'(c_sd), 32'(prev_sy));
            check("cut_rand_err_d", 32'(c_ed), 32'(prev_er));
        end
        c_en = 1'b0;

        // Full run
        run_bist(0, lat);
        check_done(lat);

        // Reset mid-run, then a clean restart
        repeat (3) tick();
        run_bist(100, lat);
        tick();
        rst = 1'b1;
        repeat (2) begin
            tick();
            check("post_abort_idle", 32'(all_outs()), 32'h0);
        end
        run_bist(0, lat);
        check_done(lat);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
